if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Parametrised instruction-fetch stage with a decoupling queue between instruction memory and decode. Holds the fetch PC, issues one request at a time over a req/ack/rvalid memory handshake, and buffers returned instructions with their PCs in a DEPTH-entry FIFO drained by a valid/ready interface. Supports absolute and PC-relative redirects, flushes the queue on redirect and discards any in-flight stale response.

## Interface
- ADDR_W, 32, PC and memory address width
- INSTR_W, 32, instruction width; multiple of 8; PC step = INSTR_W/8
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 0, PC loaded on reset; must be aligned to INSTR_W/8
- clk  input  1  main clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- taken  input  1  redirect request; highest priority
- branch_rel  input  1  0 = absolute target, 1 = PC-relative target
- branch_pc  input  ADDR_W  PC of the redirecting instruction, used when branch_rel=1
- branch_address  input  ADDR_W  absolute target, or signed offset when branch_rel=1
- imem_req  output  1  request valid
- imem_addr  output  ADDR_W  request address; held stable while imem_req=1 and imem_ack=0
- imem_ack  input  1  memory accepts request this cycle (meaningful only when imem_req=1)
- imem_rvalid  input  1  response data valid; one response per accepted request, in order
- imem_rdata  input  INSTR_W  response instruction
- out_valid  output  1  queue head valid
- out_ready  input  1  decode accepts head
- out_pc  output  ADDR_W  PC of head entry
- out_instruction  output  INSTR_W  instruction of head entry

## Operation
- Target: absolute = branch_address; relative = branch_pc + branch_address, modulo 2^ADDR_W; low log2(INSTR_W/8) bits forced to 0 in both modes.
- fetch_pc advances by INSTR_W/8 on each accepted request (imem_req & imem_ack), wrapping modulo 2^ADDR_W.
- FSM, states IDLE, REQ, WAIT, DROP; imem_req = (state==REQ); imem_addr = fetch_pc.
  - IDLE → REQ when count < DEPTH.
  - REQ → WAIT on imem_ack; else stay in REQ.
  - WAIT: on imem_rvalid, push {pc of request, imem_rdata}; → REQ if count_after_push < DEPTH, else → IDLE.
  - DROP: on imem_rvalid, discard data; → REQ.
- At most one request outstanding; queue entry reserved for it, so push never occurs when full.
- Pop on out_valid & out_ready; push and pop in the same cycle allowed, count unchanged.
- taken (sampled on clock edge, overrides all else that cycle):
  - fetch_pc ← target; queue emptied (count=0, pointers reset); that cycle's push and pop ignored.
  - REQ without ack, or IDLE → REQ (old request withdrawn, reissued next cycle at target).
  - REQ with ack, or WAIT without rvalid → DROP.
  - WAIT with rvalid → REQ, response discarded.
  - DROP without rvalid stays DROP; DROP with rvalid → REQ.
- Reset (reset=0 at edge): state IDLE, fetch_pc = RESET_PC, queue empty; any in-flight memory response after reset is the system's responsibility (memory reset with the core).

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_pc=0, out_instruction=0.
- All outputs derive from registers; no combinational path from any input to any output.
- Reset release at edge E0: E1 state REQ (imem_req=1, addr=RESET_PC); ack in cycle after E1 → WAIT at E2; rvalid in that cycle → out_valid=1 after E3.
- With ack same cycle and rvalid one cycle later, steady state is one instruction per 2 cycles.
- Redirect at edge T: first request at target visible after T+1 (REQ) or after DROP completes.
- Queue fills to DEPTH when out_ready=0; then IDLE, imem_req=0 until a pop.

## Test plan
- Reset with reset=0 for 3 cycles, RESET_PC=0x100, 1-cycle memory, out_ready=1 → out_pc sequence 0x100, 0x104, 0x108 each with matching rdata, imem_req=0 during reset.
- out_ready=0, DEPTH=4 → exactly 4 pushes (0x0–0xC), imem_req low afterwards; one pop → single new request at 0x10.
- Absolute redirect taken=1, branch_address=0x203 while in WAIT → stale rvalid discarded, next request addr 0x200, queue empty cycle after taken.
- Relative redirect branch_pc=0x40, branch_address=0xFFFFFFF0 (−16) → target 0x30; relative 0x10 from 0xFFFFFFFC wraps to 0xC.
- taken coincident with imem_ack, and separately with imem_rvalid in WAIT → no stale entry ever reaches out_valid; first output PC equals target.
- Random ack/rvalid delays, random out_ready, random redirects vs reference model → out_pc strictly sequential between redirects, no drop/duplicate, count never exceeds DEPTH.

Source files
------------

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//
// Instruction-fetch stage with a small decoupling queue between instruction
// memory and decode. Holds the fetch PC, issues one memory request at a time
// over a req/ack/rvalid handshake and buffers each returned instruction
// together with its PC. Decode drains the queue through a valid/ready port.
// A redirect (taken) loads a new fetch PC, empties the queue and discards
// any response that was already in flight.
//
// Ports
//   clk             rising-edge clock for all state
//   reset           synchronous, active-low reset
//   taken           redirect request, overrides everything else that cycle
//   branch_rel      0: target = branch_address, 1: target = branch_pc + offset
//   branch_pc       PC of the redirecting instruction (relative mode)
//   branch_address  absolute target or signed offset (relative mode)
//   imem_req        memory request valid
//   imem_addr       request address, stable while waiting for imem_ack
//   imem_ack        memory accepted the request this cycle
//   imem_rvalid     response valid (one per accepted request, in order)
//   imem_rdata      response instruction
//   out_valid       queue head valid
//   out_ready       decode accepts the head entry
//   out_pc          PC of the head entry
//   out_instruction instruction of the head entry
// ---------------------------------------------------------------------------
module if_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               taken,
    input  logic               branch_rel,
    input  logic [ADDR_W-1:0]  branch_pc,
    input  logic [ADDR_W-1:0]  branch_address,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instruction
);

    localparam int STEP  = INSTR_W / 8;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] STEP_A     = ADDR_W'(STEP);
    // Clears the byte-offset bits so every target is instruction aligned.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(STEP - 1));
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // queue full, no request outstanding
        REQ  = 2'd1,   // request presented, waiting for ack
        WAIT = 2'd2,   // request accepted, waiting for its response
        DROP = 2'd3    // a stale response is still in flight, swallow it
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic [ADDR_W-1:0]   r_req_pc;     // PC of the request currently in flight
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [ADDR_W-1:0]   r_mem_pc    [DEPTH];
    logic [INSTR_W-1:0]  r_mem_instr [DEPTH];

    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic [CNT_W-1:0]    w_count_next;
    logic [ADDR_W-1:0]   w_target_raw;
    logic [ADDR_W-1:0]   w_target;

    // Redirect target; the relative sum wraps naturally at ADDR_W bits.
    assign w_target_raw = branch_rel ? (branch_pc + branch_address) : branch_address;
    assign w_target     = w_target_raw & ALIGN_MASK;

    assign w_accept = (r_state == REQ) && imem_ack;
    // A redirect cancels the push and pop of its own cycle.
    assign w_push   = (r_state == WAIT) && imem_rvalid && !taken;
    assign w_pop    = (r_count != '0) && out_ready && !taken;

    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Control: fetch PC, queue pointers/occupancy and the request FSM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (taken) begin
            r_fetch_pc <= w_target;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            // Anything accepted but not yet returned must be swallowed in DROP
            // so it can never be mistaken for a response to the new target.
            case (r_state)
                IDLE:    r_state <= REQ;
                REQ:     r_state <= imem_ack    ? DROP : REQ;
                WAIT:    r_state <= imem_rvalid ? REQ  : DROP;
                DROP:    r_state <= imem_rvalid ? REQ  : DROP;
                default: r_state <= IDLE;
            endcase
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + STEP_A;
                r_req_pc   <= r_fetch_pc;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_next;

            // A request is only issued while a free slot exists, and nothing
            // else can fill that slot before the response arrives, so the
            // push in WAIT can never overflow the queue.
            case (r_state)
                IDLE: begin
                    if (r_count < DEPTH_C) begin
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        r_state <= (w_count_next < DEPTH_C) ? REQ : IDLE;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        r_state <= REQ;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Queue storage. Cleared on reset so the head outputs read zero while
    // the queue has never been written.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_pc[i]    <= '0;
                r_mem_instr[i] <= '0;
            end
        end else if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_req_pc;
            r_mem_instr[r_wr_ptr] <= imem_rdata;
        end
    end

    // All outputs come straight from registers.
    assign imem_req        = (r_state == REQ);
    assign imem_addr       = r_fetch_pc;
    assign out_valid       = (r_count != '0);
    assign out_pc          = r_mem_pc[r_rd_ptr];
    assign out_instruction = r_mem_instr[r_rd_ptr];

endmodule

// File: tb/tb_if_fetch_queue.sv
// ---------------------------------------------------------------------------
// Testbench for if_fetch_queue (ADDR_W=32, INSTR_W=32, DEPTH=4,
// RESET_PC=0x100). A behavioural memory responds to requests; a
// transaction-level model tracks the next expected request address, the
// next expected output PC and the queue occupancy.
// ---------------------------------------------------------------------------
module tb_if_fetch_queue;

    localparam int          ADDR_W   = 32;
    localparam int          INSTR_W  = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] STEP     = 32'd4;

    logic        clk = 1'b0;
    logic        reset;
    logic        taken;
    logic        branch_rel;
    logic [31:0] branch_pc;
    logic [31:0] branch_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;

    always #5 clk = ~clk;

    if_fetch_queue #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .taken           (taken),
        .branch_rel      (branch_rel),
        .branch_pc       (branch_pc),
        .branch_address  (branch_address),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instruction (out_instruction)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] exp_fetch;     // address of the next request that should be accepted
    logic [31:0] exp_out;       // PC of the next entry decode should see
    int          mcount;        // live entries in the queue
    // Memory model state
    bit          pend;
    bit          pend_stale;
    logic [31:0] pend_addr;
    int          pend_delay;
    int          ack_mode;      // 0 never, 1 always, 2 random
    int          rv_lo;
    int          rv_hi;
    logic [31:0] pop_log[$];
    logic [31:0] acc_log[$];

    typedef struct {
        logic        rel;
        logic [31:0] bpc;
        logic [31:0] baddr;
        logic [31:0] exp_addr;
    } vec_t;
    vec_t vecs[6];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    function automatic logic [31:0] model_target(input logic rel, input logic [31:0] bpc,
                                                 input logic [31:0] baddr);
        logic [31:0] t;
        t = rel ? bpc + baddr : baddr;
        return {t[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] log_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_DEAD;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: record pre-edge values, advance, update model and
    // memory from what happened at the edge, then drive the next cycle.
    task automatic cycle();
        logic        p_taken, p_rel, p_ack, p_rvalid, p_req, p_or, p_reset;
        logic [31:0] p_bpc, p_baddr, p_addr, p_opc, p_oi, t;
        bit          resp_stale, pop;
        p_taken  = taken;       p_rel    = branch_rel;
        p_bpc    = branch_pc;   p_baddr  = branch_address;
        p_ack    = imem_ack;    p_rvalid = imem_rvalid;
        p_req    = imem_req;    p_addr   = imem_addr;
        p_or     = out_ready;   p_opc    = out_pc;
        p_oi     = out_instruction;
        p_reset  = reset;
        @(posedge clk);
        #1;
        if (!p_reset) begin
            exp_fetch  = RESET_PC;
            exp_out    = RESET_PC;
            mcount     = 0;
            pend       = 0;
            pend_stale = 0;
        end else begin
            resp_stale = pend_stale;
            if (p_rvalid) begin
                pend       = 0;
                pend_stale = 0;
            end
            if (p_taken) begin
                t = model_target(p_rel, p_bpc, p_baddr);
                if (pend) pend_stale = 1;
                if (p_req && p_ack) begin
                    pend       = 1;
                    pend_addr  = p_addr;
                    pend_delay = $urandom_range(rv_hi, rv_lo);
                    pend_stale = 1;
                end
                exp_fetch = t;
                exp_out   = t;
                mcount    = 0;
            end else begin
                pop = (mcount > 0) && p_or;
                if (p_rvalid && !resp_stale) mcount++;
                if (pop) begin
                    check32("pop_pc", p_opc, exp_out);
                    check32("pop_instr", p_oi, instr_of(exp_out));
                    pop_log.push_back(exp_out);
                    exp_out += STEP;
                    mcount--;
                end
                if (p_req && p_ack) begin
                    check32("req_addr", p_addr, exp_fetch);
                    acc_log.push_back(p_addr);
                    exp_fetch += STEP;
                    pend       = 1;
                    pend_addr  = p_addr;
                    pend_delay = $urandom_range(rv_hi, rv_lo);
                    pend_stale = 0;
                end
            end
        end
        check32("out_valid", 32'(out_valid), 32'(mcount != 0));
        checks++;
        if (mcount > DEPTH) begin
            errors++;
            $display("FAIL occupancy: count %0d, limit %0d", mcount, DEPTH);
        end
        // Memory drive for the coming cycle
        if (pend) begin
            if (pend_delay == 0) imem_rvalid = 1'b1;
            else begin
                pend_delay--;
                imem_rvalid = 1'b0;
            end
        end else begin
            imem_rvalid = 1'b0;
        end
        imem_rdata = imem_rvalid ? instr_of(pend_addr) : $urandom;
        imem_ack   = imem_req && (ack_mode == 1 || (ack_mode == 2 && $urandom_range(0, 1) == 1));
    endtask

    task automatic redirect(input logic rel, input logic [31:0] bpc, input logic [31:0] baddr);
        taken = 1'b1; branch_rel = rel; branch_pc = bpc; branch_address = baddr;
        cycle();
        taken = 1'b0;
    endtask

    task automatic wait_pop(input string name);
        for (int k = 0; k < 60 && pop_log.size() == 0; k++) cycle();
        check32(name, 32'(pop_log.size() != 0), 32'd1);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h0,          32'h0000_0203, 32'h0000_0200};
        vecs[1] = '{1'b1, 32'h0000_0040,  32'hFFFF_FFF0, 32'h0000_0030};
        vecs[2] = '{1'b1, 32'hFFFF_FFFC,  32'h0000_0010, 32'h0000_000C};
        vecs[3] = '{1'b0, 32'h1234_5678,  32'hFFFF_FFFF, 32'hFFFF_FFFC};
        vecs[4] = '{1'b1, 32'h0000_1000,  32'h0000_0007, 32'h0000_1004};
        vecs[5] = '{1'b1, 32'h8000_0000,  32'h8000_0002, 32'h0000_0000};

        reset = 1'b0; taken = 1'b0; branch_rel = 1'b0;
        branch_pc = '0; branch_address = '0;
        imem_ack = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        out_ready = 1'b1;
        pend = 0; pend_stale = 0; pend_addr = '0; pend_delay = 0;
        mcount = 0; exp_fetch = RESET_PC; exp_out = RESET_PC;
        ack_mode = 1; rv_lo = 0; rv_hi = 0;

        // Reset held low for three edges
        repeat (3) begin
            cycle();
            check32("rst_req", 32'(imem_req), 32'd0);
            check32("rst_addr", imem_addr, RESET_PC);
            check32("rst_out_pc", out_pc, 32'h0);
            check32("rst_out_instr", out_instruction, 32'h0);
        end
        $display("reset: req=%0d addr=%h", imem_req, imem_addr);

        // First fetch latency and steady state with a one-cycle memory
        reset = 1'b1;
        cycle();
        check32("e1_req", 32'(imem_req), 32'd1);
        check32("e1_addr", imem_addr, RESET_PC);
        cycle();
        check32("e2_req", 32'(imem_req), 32'd0);
        cycle();
        check32("e3_valid", 32'(out_valid), 32'd1);
        check32("e3_pc", out_pc, RESET_PC);
        check32("e3_instr", out_instruction, instr_of(RESET_PC));
        pop_log.delete();
        repeat (6) cycle();
        check32("seq_count", 32'(pop_log.size()), 32'd3);
        check32("seq0", log_at(pop_log, 0), 32'h100);
        check32("seq1", log_at(pop_log, 1), 32'h104);
        check32("seq2", log_at(pop_log, 2), 32'h108);
        foreach (pop_log[i]) $display("seq pop pc=%h", pop_log[i]);

        // Fill the queue with decode stalled
        out_ready = 1'b0;
        redirect(1'b0, 32'h0, 32'h0);
        acc_log.delete(); pop_log.delete();
        repeat (20) cycle();
        check32("fill_count", 32'(acc_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) check32("fill_addr", log_at(acc_log, i), 32'(4 * i));
        check32("fill_req_low", 32'(imem_req), 32'd0);
        check32("fill_head", out_pc, 32'h0);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check32("fill_pop", 32'(pop_log.size()), 32'd1);
        repeat (10) cycle();
        check32("refill_count", 32'(acc_log.size()), 32'd5);
        check32("refill_addr", log_at(acc_log, 4), 32'h10);
        check32("refill_req_low", 32'(imem_req), 32'd0);
        $display("fill: accepted=%0d last=%h", acc_log.size(), log_at(acc_log, 4));

        // Absolute redirect while a response is pending
        out_ready = 1'b1; rv_lo = 3; rv_hi = 3;
        for (int k = 0; k < 40 && !(pend && !pend_stale && !imem_rvalid); k++) cycle();
        check32("wait_reached", 32'(pend && !pend_stale), 32'd1);
        redirect(1'b0, 32'h0, 32'h0000_0203);
        check32("abs_flush", 32'(out_valid), 32'd0);
        check32("abs_addr", imem_addr, 32'h200);
        check32("abs_drop_req", 32'(imem_req), 32'd0);
        acc_log.delete(); pop_log.delete();
        wait_pop("abs_timeout");
        check32("abs_first_req", log_at(acc_log, 0), 32'h200);
        check32("abs_first_out", log_at(pop_log, 0), 32'h200);
        $display("abs redirect: first out pc=%h", log_at(pop_log, 0));

        // Target computation vectors, memory never acknowledging
        ack_mode = 0; rv_lo = 0; rv_hi = 0;
        for (int v = 0; v < 6; v++) begin
            redirect(vecs[v].rel, vecs[v].bpc, vecs[v].baddr);
            check32("vec_addr", imem_addr, vecs[v].exp_addr);
            check32("vec_flush", 32'(out_valid), 32'd0);
            $display("vec %0d rel=%0d pc=%h off=%h -> addr=%h", v, vecs[v].rel,
                     vecs[v].bpc, vecs[v].baddr, imem_addr);
        end
        repeat (3) cycle();
        check32("hold_addr", imem_addr, vecs[5].exp_addr);
        check32("hold_req", 32'(imem_req), 32'd1);

        // Redirect in the same cycle as an ack
        ack_mode = 1; rv_lo = 1; rv_hi = 1;
        for (int k = 0; k < 20 && !(imem_req && imem_ack); k++) cycle();
        check32("ack_reached", 32'(imem_req && imem_ack), 32'd1);
        redirect(1'b0, 32'h0, 32'h0000_0500);
        check32("ack_drop_req", 32'(imem_req), 32'd0);
        pop_log.delete();
        wait_pop("ack_timeout");
        check32("ack_first_out", log_at(pop_log, 0), 32'h500);
        $display("redirect on ack: first out pc=%h", log_at(pop_log, 0));

        // Redirect in the same cycle as a live response
        rv_lo = 0; rv_hi = 0;
        for (int k = 0; k < 20 && !(imem_rvalid && !pend_stale); k++) cycle();
        check32("rv_reached", 32'(imem_rvalid && !pend_stale), 32'd1);
        redirect(1'b0, 32'h0, 32'h0000_0600);
        check32("rv_flush", 32'(out_valid), 32'd0);
        check32("rv_req", 32'(imem_req), 32'd1);
        check32("rv_addr", imem_addr, 32'h600);
        pop_log.delete();
        wait_pop("rv_timeout");
        check32("rv_first_out", log_at(pop_log, 0), 32'h600);
        $display("redirect on rvalid: first out pc=%h", log_at(pop_log, 0));

        // Randomised traffic against the model
        ack_mode = 2; rv_lo = 0; rv_hi = 3;
        pop_log.delete();
        for (int n = 0; n < 3000; n++) begin
            out_ready  = ($urandom_range(0, 3) != 0);
            taken      = ($urandom_range(0, 31) == 0);
            branch_rel = $urandom_range(0, 1) == 1;
            branch_pc  = $urandom;
            branch_address = branch_rel ? (32'($urandom_range(0, 255)) - 32'd128) : $urandom;
            cycle();
        end
        taken = 1'b0; out_ready = 1'b1;
        repeat (30) cycle();
        check32("random_progress", 32'(pop_log.size() > 100), 32'd1);
        $display("random: %0d entries delivered", pop_log.size());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
